// File: rtl/regfile_loader.sv
// Loads a byte stream into consecutive register-file addresses, then reads each
// written location back through port 1 and flags the first mismatch.
module regfile_loader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [AW-1:0]    A3,
  output logic [WIDTH-1:0] WD3,
  output logic             WE3,
  output logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] RD1,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    err_addr
);

  localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    base_q;
  logic [AW:0]      n_q, idx, cnt_sat;
  logic [AW-1:0]    cur_addr;
  logic             hs, last, mism;
  logic [WIDTH-1:0] shadow [DEPTH];

  assign cnt_sat  = (count > NMAX) ? NMAX : count;
  assign cur_addr = base_q + idx[AW-1:0];
  assign hs       = in_valid & in_ready;
  assign last     = (idx == n_q - ONE);
  assign mism     = (RD1 != shadow[idx[AW-1:0]]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cnt_sat == '0) ? DONE : LOAD;
      LOAD:    if (hs && last) state_nxt = DRAIN;
      DRAIN:   state_nxt = VERIFY;
      VERIFY:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so async reset clears them at once.
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state != IDLE);
    done     = (state == DONE);
    A1       = (state == VERIFY) ? cur_addr : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      n_q      <= '0;
      idx      <= '0;
      A3       <= '0;
      WD3      <= '0;
      WE3      <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      WE3 <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_q   <= base;
          n_q      <= cnt_sat;
          idx      <= '0;
          err      <= 1'b0;
          err_addr <= '0;
        end
        LOAD: if (hs) begin
          A3  <= cur_addr;
          WD3 <= in_data;
          WE3 <= 1'b1;
          idx <= last ? '0 : idx + ONE;
        end
        VERIFY: begin
          if (mism && !err) begin
            err      <= 1'b1;
            err_addr <= cur_addr;
          end
          idx <= idx + ONE;
        end
        default: ;
      endcase
    end
  end

  // Shadow needs no reset: every entry is written in LOAD before VERIFY reads it.
  always_ff @(posedge clk) begin
    if (state == LOAD && hs) shadow[idx[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_regfile_loader.sv
// Randomized bench for regfile_loader: per-cycle output traces are compared with
// a cycle-level model derived from the handshake pattern and byte list.
module tb_regfile_loader;

  logic       clk, reset, start, in_valid, in_ready, WE3, busy, done, err;
  logic [2:0] base, A3, A1, err_addr;
  logic [3:0] count;
  logic [7:0] in_data, WD3, RD1;

  logic [7:0] rf [8];
  bit         cor_en;
  logic [2:0] cor_a;

  int vectors = 0, miscompares = 0;

  logic [21:0] obs[$], ex[$];
  logic [7:0]  tx[$];
  bit          vpat[100];
  int          xstart_c = -1;
  logic [2:0]  xbase;
  logic [2:0]  m_a3, m_erra;
  logic [7:0]  m_wd3;
  logic        m_err;

  regfile_loader #(.DEPTH(8), .WIDTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .A3(A3), .WD3(WD3), .WE3(WE3), .A1(A1), .RD1(RD1),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  always @(posedge clk) if (WE3) rf[A3] <= WD3;
  assign RD1 = (cor_en && A1 == cor_a) ? 8'h00 : rf[A1];

  task automatic set_vpat(input int mode);
    for (int c = 0; c < 100; c++)
      vpat[c] = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
  endtask

  // Expected trace: writes land one cycle after each handshake, one DRAIN cycle,
  // N VERIFY cycles, one DONE cycle, then one IDLE cycle.
  task automatic build_exp(input logic [2:0] b, input logic [3:0] cnt);
    int n, last, dc, j0;
    int h[$];
    ex.delete();
    n = (cnt > 8) ? 8 : int'(cnt);
    for (int c = 1; c < 100 && h.size() < n; c++) if (vpat[c]) h.push_back(c);
    last = (n > 0) ? h[n-1] : 0;
    dc   = (n > 0) ? last + n + 2 : 1;
    j0 = -1;
    for (int j = 0; j < n; j++)
      if (j0 < 0 && cor_en && 3'(b + j) == cor_a && tx[j] != 8'h00) j0 = j;
    for (int c = 1; c <= dc + 1; c++) begin
      logic rdy, bsy, dn, we;
      logic [2:0] a1;
      rdy = (n > 0) && (c <= last);
      bsy = (c <= dc);
      dn  = (c == dc);
      we  = 1'b0;
      a1  = 3'd0;
      for (int i = 0; i < n; i++)
        if (h[i] + 1 == c) begin we = 1'b1; m_a3 = 3'(b + i); m_wd3 = tx[i]; end
      if (n > 0 && c >= last + 2 && c < last + 2 + n) a1 = 3'(b + (c - last - 2));
      if (c == 1) begin m_err = 1'b0; m_erra = 3'd0; end
      if (j0 >= 0 && c == last + 3 + j0) begin m_err = 1'b1; m_erra = 3'(b + j0); end
      ex.push_back({rdy, bsy, dn, we, m_err, m_erra, m_a3, a1, m_wd3});
    end
  endtask

  task automatic run_load(input logic [2:0] b, input logic [3:0] cnt);
    int  c, bi;
    bit  seen;
    obs.delete();
    @(negedge clk); start = 1; base = b; count = cnt; in_valid = 0;
    @(negedge clk); start = 0; c = 1; bi = 0; seen = 0;
    forever begin
      obs.push_back({in_ready, busy, done, WE3, err, err_addr, A3, A1, WD3});
      if (seen || c >= 80) break;
      if (done) seen = 1;
      start    = (c == xstart_c);
      base     = start ? xbase : b;
      in_valid = vpat[c] && (bi < tx.size());
      in_data  = in_valid ? tx[bi] : 8'($urandom);
      if (in_ready && in_valid) bi++;
      @(negedge clk); c++;
    end
    start = 0; in_valid = 0;
  endtask

  task automatic test_reset;
    reset = 0; start = 0; base = 0; count = 0; in_valid = 0; in_data = 0; cor_en = 0; cor_a = 0;
    m_a3 = 0; m_wd3 = 0; m_err = 0; m_erra = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, busy, done, WE3, err, err_addr, A3, A1, WD3} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset outputs got %h exp 0", {in_ready, busy, done, WE3, err, err_addr, A3, A1, WD3});
    end
    reset = 1;
  endtask

  task automatic test_basic;
    tx.delete(); for (int k = 0; k < 8; k++) tx.push_back(8'(8'h10 + k));
    set_vpat(0); build_exp(3'd0, 4'd8); run_load(3'd0, 4'd8);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL basic length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL basic cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (rf[k] !== 8'(8'h10 + k)) begin miscompares++; $display("FAIL basic rf[%0d] got %h exp %h", k, rf[k], 8'(8'h10 + k)); end
    end
  endtask

  task automatic test_wrap_stall;
    tx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    set_vpat(1); build_exp(3'd6, 4'd4); run_load(3'd6, 4'd4);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL wrap length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL wrap cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
  endtask

  task automatic test_mismatch;
    tx = '{8'h55, 8'h66, 8'h77};
    cor_en = 1; cor_a = 3'd3;
    set_vpat(0); build_exp(3'd2, 4'd3); run_load(3'd2, 4'd3);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL mismatch length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL mismatch cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
    cor_en = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || err_addr !== 3'd3) begin
      miscompares++; $display("FAIL mismatch sticky got err=%b addr=%0d exp err=1 addr=3", err, err_addr);
    end
    tx = '{8'h01, 8'h02};
    build_exp(3'd0, 4'd2); run_load(3'd0, 4'd2);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL clear length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL clear cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
  endtask

  task automatic test_edge_counts;
    tx.delete(); set_vpat(0);
    build_exp(3'd5, 4'd0); run_load(3'd5, 4'd0);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL count0 length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL count0 cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
    for (int k = 0; k < 12; k++) tx.push_back(8'(8'hE0 + k));
    build_exp(3'd1, 4'd12); run_load(3'd1, 4'd12);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL count12 length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL count12 cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] prev2;
    prev2 = rf[2];
    tx = '{8'hC0, 8'hC1, 8'hC2};
    @(negedge clk); start = 1; base = 0; count = 8; in_valid = 0;
    @(negedge clk); start = 0; in_valid = 1; in_data = tx[0];
    @(negedge clk); in_data = tx[1];
    @(negedge clk); in_data = tx[2];
    @(posedge clk); #2;
    vectors++;
    if (WE3 !== 1'b1 || A3 !== 3'd2) begin miscompares++; $display("FAIL rstmid pre got WE3=%b A3=%0d exp WE3=1 A3=2", WE3, A3); end
    reset = 0; #1;
    vectors++;
    if ({WE3, in_ready, busy, done, err, A3, WD3, A1} !== 17'h0) begin
      miscompares++; $display("FAIL rstmid async got %h exp 0", {WE3, in_ready, busy, done, err, A3, WD3, A1});
    end
    in_valid = 0;
    m_a3 = 0; m_wd3 = 0; m_err = 0; m_erra = 0;
    @(negedge clk); reset = 1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rf[0] !== 8'hC0 || rf[1] !== 8'hC1 || rf[2] !== prev2) begin
      miscompares++; $display("FAIL rstmid after got busy=%b rf0=%h rf1=%h rf2=%h exp 0 c0 c1 %h", busy, rf[0], rf[1], rf[2], prev2);
    end
    tx = '{8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E};
    set_vpat(0); build_exp(3'd3, 4'd5); run_load(3'd3, 4'd5);
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL rstmid rerun length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL rstmid rerun cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
  endtask

  task automatic test_start_busy;
    tx = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    xstart_c = 8; xbase = 3'd6;
    set_vpat(0); build_exp(3'd1, 4'd5); run_load(3'd1, 4'd5);
    xstart_c = -1;
    vectors++;
    if (obs.size() != ex.size()) begin miscompares++; $display("FAIL startbusy length got %0d exp %0d", obs.size(), ex.size()); end
    foreach (ex[i]) if (i < obs.size()) begin
      vectors++;
      if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL startbusy cycle %0d got %h exp %h", i+1, obs[i], ex[i]); end
    end
  endtask

  task automatic test_random;
    logic [2:0] b;
    logic [3:0] cnt;
    for (int it = 0; it < 10; it++) begin
      b = 3'($urandom); cnt = 4'($urandom_range(0, 12));
      tx.delete(); for (int k = 0; k < 12; k++) tx.push_back(8'($urandom));
      cor_en = 1'($urandom_range(0, 1)); cor_a = 3'($urandom);
      set_vpat(2); build_exp(b, cnt); run_load(b, cnt);
      vectors++;
      if (obs.size() != ex.size()) begin miscompares++; $display("FAIL random%0d length got %0d exp %0d", it, obs.size(), ex.size()); end
      foreach (ex[i]) if (i < obs.size()) begin
        vectors++;
        if (obs[i] !== ex[i]) begin miscompares++; $display("FAIL random%0d cycle %0d got %h exp %h", it, i+1, obs[i], ex[i]); end
      end
    end
    cor_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_stall();
    test_mismatch();
    test_edge_counts();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
